// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch unit, the load/store unit and the shared memory port.
// The arbiter uses the slave modport; the requesters and memory model sit on the master side.
interface mem_port_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_mask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_mask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_mask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// LSU has priority; a saturating counter forces an IFU win after STARVE_MAX deferrals.
//   state | meaning
//   IDLE  | no transaction; combinational arbitration, winner sees ready
//   ISSUE | latched request presented on mem_req_*, waiting for mem_req_ready
//   WAIT  | accepted; waiting for mem_resp_valid, routed to the owner
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;

  logic force_ifu;
  logic grant_lsu;
  logic grant_ifu;
  logic resp_fire;

  // Grants are gated by reset so no ready escapes while reset is held.
  always_comb begin
    force_ifu = (cnt_q == STARVE_CNT) && bus.ifu_req_valid;
    grant_lsu = reset_n && (state_q == S_IDLE) && bus.lsu_req_valid && !force_ifu;
    grant_ifu = reset_n && (state_q == S_IDLE) && bus.ifu_req_valid && !grant_lsu;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= 64'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 64'h0;
      mask_q      <= 8'h0;
      cnt_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          state_d     = S_ISSUE;
          owner_lsu_d = 1'b1;
          addr_d      = bus.lsu_req_addr;
          wen_d       = bus.lsu_req_wen;
          wdata_d     = bus.lsu_req_wdata;
          mask_d      = bus.lsu_req_mask;
          if (bus.ifu_req_valid)
            cnt_d = (cnt_q >= STARVE_CNT) ? STARVE_CNT : cnt_q + 4'd1;
          else
            cnt_d = 4'd0;
        end else if (grant_ifu) begin
          state_d     = S_ISSUE;
          owner_lsu_d = 1'b0;
          addr_d      = bus.ifu_req_addr;
          wen_d       = 1'b0;
          wdata_d     = 64'h0;
          mask_d      = 8'h0F;
          cnt_d       = 4'd0;
        end
      end
      S_ISSUE: if (bus.mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_fire          = (state_q == S_WAIT) && bus.mem_resp_valid;
    bus.ifu_req_ready  = grant_ifu;
    bus.lsu_req_ready  = grant_lsu;
    bus.mem_req_valid  = (state_q == S_ISSUE);
    bus.mem_req_addr   = addr_q;
    bus.mem_req_wen    = wen_q;
    bus.mem_req_wdata  = wdata_q;
    bus.mem_req_mask   = mask_q;
    bus.ifu_resp_valid = resp_fire && !owner_lsu_q;
    bus.lsu_resp_valid = resp_fire && owner_lsu_q;
    bus.ifu_resp_data  = (resp_fire && !owner_lsu_q) ? bus.mem_resp_data : 64'h0;
    bus.lsu_resp_data  = (resp_fire && owner_lsu_q && !wen_q) ? bus.mem_resp_data : 64'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: at most one transaction, either not yet accepted or accepted.
  bit          m_busy, m_acc, m_lsu, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_mask;
  int          m_streak;
  bit          g_if, g_ls;

  bit          ifu_pend, lsu_pend;
  int          order[10];
  int          ngr;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare at the falling edge, inputs having been stable since just after the rising edge.
  task automatic settle();
    bit e_if_rdy, e_ls_rdy, e_mv, e_if_rv, e_ls_rv;
    @(negedge clock);
    e_if_rdy = 0; e_ls_rdy = 0; e_mv = 0; e_if_rv = 0; e_ls_rv = 0;
    if (!m_busy) begin
      e_ls_rdy = bus.lsu_req_valid && !(m_streak >= SM && bus.ifu_req_valid);
      e_if_rdy = !e_ls_rdy && bus.ifu_req_valid;
    end else if (!m_acc) begin
      e_mv = 1;
    end else if (bus.mem_resp_valid) begin
      if (m_lsu) e_ls_rv = 1;
      else       e_if_rv = 1;
    end
    chk1("m_ifu_ready", bus.ifu_req_ready, e_if_rdy);
    chk1("m_lsu_ready", bus.lsu_req_ready, e_ls_rdy);
    chk1("m_mem_valid", bus.mem_req_valid, e_mv);
    chk1("m_ifu_resp_valid", bus.ifu_resp_valid, e_if_rv);
    chk1("m_lsu_resp_valid", bus.lsu_resp_valid, e_ls_rv);
    if (e_mv) begin
      chk64("m_mem_addr", bus.mem_req_addr, m_addr);
      chk1("m_mem_wen", bus.mem_req_wen, m_wen);
      chk64("m_mem_wdata", bus.mem_req_wdata, m_wdata);
      chk64("m_mem_mask", 64'(bus.mem_req_mask), 64'(m_mask));
    end
    if (e_if_rv) chk64("m_ifu_resp_data", bus.ifu_resp_data, bus.mem_resp_data);
    if (e_ls_rv) chk64("m_lsu_resp_data", bus.lsu_resp_data, m_wen ? 64'h0 : bus.mem_resp_data);
    g_if = e_if_rdy;
    g_ls = e_ls_rdy;
  endtask

  task automatic advance();
    if (g_ls) begin
      m_busy = 1; m_acc = 0; m_lsu = 1;
      m_addr = bus.lsu_req_addr; m_wen = bus.lsu_req_wen;
      m_wdata = bus.lsu_req_wdata; m_mask = bus.lsu_req_mask;
      m_streak = bus.ifu_req_valid ? ((m_streak + 1 > SM) ? SM : m_streak + 1) : 0;
    end else if (g_if) begin
      m_busy = 1; m_acc = 0; m_lsu = 0;
      m_addr = bus.ifu_req_addr; m_wen = 0; m_wdata = 64'h0; m_mask = 8'h0F;
      m_streak = 0;
    end else if (m_busy && !m_acc) begin
      if (bus.mem_req_ready) m_acc = 1;
    end else if (m_busy && bus.mem_resp_valid) begin
      m_busy = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid = 0; bus.ifu_req_addr = 64'h0;
    bus.lsu_req_valid = 0; bus.lsu_req_addr = 64'h0; bus.lsu_req_wen = 0;
    bus.lsu_req_wdata = 64'h0; bus.lsu_req_mask = 8'h0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 64'h0;
  endtask

  // Called just after a rising edge; provokes every input while reset is held.
  task automatic do_reset();
    reset_n = 0;
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
    bus.mem_req_ready = 1; bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    m_busy = 0; m_acc = 0; m_lsu = 0; m_streak = 0; g_if = 0; g_ls = 0;
    #2;
    chk1("rst_ifu_ready", bus.ifu_req_ready, 1'b0);
    chk1("rst_lsu_ready", bus.lsu_req_ready, 1'b0);
    chk1("rst_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
    chk1("rst_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
    chk1("rst_mem_valid", bus.mem_req_valid, 1'b0);
    chk64("rst_mem_addr", bus.mem_req_addr, 64'h0);
    chk64("rst_mem_wdata", bus.mem_req_wdata, 64'h0);
    chk64("rst_mem_mask", 64'(bus.mem_req_mask), 64'h0);
    chk1("rst_mem_wen", bus.mem_req_wen, 1'b0);
    chk64("rst_ifu_resp_data", bus.ifu_resp_data, 64'h0);
    chk64("rst_lsu_resp_data", bus.lsu_resp_data, 64'h0);
    repeat (2) @(posedge clock);
    #1;
    clear_inputs();
    reset_n = 1;
  endtask

  task automatic rand_drive();
    if (!ifu_pend && $urandom_range(0, 2) == 0) begin
      ifu_pend = 1;
      bus.ifu_req_addr = {$urandom, $urandom};
    end
    if (!lsu_pend && $urandom_range(0, 1) == 0) begin
      lsu_pend = 1;
      bus.lsu_req_addr  = {$urandom, $urandom};
      bus.lsu_req_wen   = 1'($urandom_range(0, 1));
      bus.lsu_req_wdata = {$urandom, $urandom};
      bus.lsu_req_mask  = 8'($urandom_range(0, 255));
    end
    bus.ifu_req_valid = ifu_pend;
    bus.lsu_req_valid = lsu_pend;
    bus.mem_req_ready = ($urandom_range(0, 2) != 0);
    if (m_busy && m_acc) bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
    else                 bus.mem_resp_valid = ($urandom_range(0, 7) == 0);
    bus.mem_resp_data = {$urandom, $urandom};
  endtask

  initial begin
    int exp_order[10];
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    clear_inputs();
    #1;
    do_reset();

    // IFU only, zero-wait memory
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_0000; bus.mem_req_ready = 1;
    settle();
    chk1("t1_ifu_ready_c0", bus.ifu_req_ready, 1'b1);
    chk1("t1_lsu_ready_c0", bus.lsu_req_ready, 1'b0);
    advance();
    bus.ifu_req_valid = 0;
    settle();
    chk1("t1_mem_valid_c1", bus.mem_req_valid, 1'b1);
    chk64("t1_mem_mask_c1", 64'(bus.mem_req_mask), 64'h0F);
    chk1("t1_mem_wen_c1", bus.mem_req_wen, 1'b0);
    chk64("t1_mem_addr_c1", bus.mem_req_addr, 64'h8000_0000);
    advance();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h0000_0013;
    settle();
    chk1("t1_ifu_resp_valid_c2", bus.ifu_resp_valid, 1'b1);
    chk64("t1_ifu_resp_data_c2", bus.ifu_resp_data, 64'h13);
    chk1("t1_lsu_resp_valid_c2", bus.lsu_resp_valid, 1'b0);
    advance();
    bus.mem_resp_valid = 0;

    // LSU store with three wait cycles on mem_req_ready
    bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_1000; bus.lsu_req_wen = 1;
    bus.lsu_req_wdata = 64'hDEAD_BEEF; bus.lsu_req_mask = 8'hFF; bus.mem_req_ready = 0;
    settle();
    chk1("t2_lsu_ready", bus.lsu_req_ready, 1'b1);
    advance();
    bus.lsu_req_valid = 0; bus.lsu_req_addr = 64'h0; bus.lsu_req_wdata = 64'h0; bus.lsu_req_mask = 8'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk1("t2_mem_valid_wait", bus.mem_req_valid, 1'b1);
      chk64("t2_mem_addr_wait", bus.mem_req_addr, 64'h8000_1000);
      chk64("t2_mem_wdata_wait", bus.mem_req_wdata, 64'hDEAD_BEEF);
      chk64("t2_mem_mask_wait", 64'(bus.mem_req_mask), 64'hFF);
      chk1("t2_mem_wen_wait", bus.mem_req_wen, 1'b1);
      advance();
    end
    bus.mem_req_ready = 1;
    settle();
    chk1("t2_mem_valid_accept", bus.mem_req_valid, 1'b1);
    advance();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h1234_5678_9ABC_DEF0;
    settle();
    chk1("t2_lsu_resp_valid", bus.lsu_resp_valid, 1'b1);
    chk64("t2_lsu_resp_data", bus.lsu_resp_data, 64'h0);
    chk1("t2_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
    advance();
    bus.mem_resp_valid = 0;

    // Simultaneous requests: LSU first, IFU in the following IDLE
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_0100;
    bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_0200; bus.lsu_req_wen = 0;
    bus.lsu_req_mask = 8'h0F;
    settle();
    chk1("t3_lsu_ready_first", bus.lsu_req_ready, 1'b1);
    chk1("t3_ifu_ready_first", bus.ifu_req_ready, 1'b0);
    advance();
    bus.lsu_req_valid = 0;
    settle();
    chk1("t3_ifu_ready_issue", bus.ifu_req_ready, 1'b0);
    advance();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h77;
    settle();
    chk64("t3_lsu_load_data", bus.lsu_resp_data, 64'h77);
    advance();
    bus.mem_resp_valid = 0;
    settle();
    chk1("t3_ifu_ready_next", bus.ifu_req_ready, 1'b1);
    advance();
    bus.ifu_req_valid = 0;
    settle();
    chk64("t3_ifu_mem_addr", bus.mem_req_addr, 64'h8000_0100);
    advance();
    bus.mem_resp_valid = 1;
    settle();
    chk1("t3_ifu_resp_valid", bus.ifu_resp_valid, 1'b1);
    advance();
    bus.mem_resp_valid = 0;

    // Starvation: both valid continuously, grant order LLLLILLLLI
    do_reset();
    ngr = 0;
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.lsu_req_wen = 0; bus.mem_req_ready = 1;
    for (int c = 0; c < 100 && ngr < 10; c++) begin
      bus.mem_resp_valid = m_busy && m_acc;
      bus.mem_resp_data = 64'(c);
      settle();
      if (bus.lsu_req_ready) begin order[ngr] = 1; ngr++; end
      else if (bus.ifu_req_ready) begin order[ngr] = 0; ngr++; end
      advance();
      bus.ifu_req_addr = 64'h9000_0000 + 64'(c);
      bus.lsu_req_addr = 64'hA000_0000 + 64'(c);
    end
    if (ngr < 10) begin
      n_cmp++; n_bad++;
      $display("FAIL starve_timeout: got %0d grants expected 10", ngr);
    end
    for (int i = 0; i < ngr; i++)
      chk64("starve_order", 64'(order[i]), 64'(exp_order[i]));
    clear_inputs();
    repeat (4) begin
      bus.mem_resp_valid = m_busy && m_acc;
      bus.mem_req_ready = 1;
      settle();
      advance();
    end
    clear_inputs();

    // Reset in WAIT, stale response afterwards
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_2000; bus.mem_req_ready = 1;
    settle();
    advance();
    bus.ifu_req_valid = 0;
    settle();
    advance();
    bus.mem_req_ready = 0;
    settle();
    chk1("t5_in_wait_no_resp", bus.ifu_resp_valid, 1'b0);
    advance();
    do_reset();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hBAD;
    settle();
    chk1("t5_stale_ifu_resp", bus.ifu_resp_valid, 1'b0);
    chk1("t5_stale_lsu_resp", bus.lsu_resp_valid, 1'b0);
    chk1("t5_stale_mem_valid", bus.mem_req_valid, 1'b0);
    chk64("t5_stale_ifu_data", bus.ifu_resp_data, 64'h0);
    advance();
    bus.mem_resp_valid = 0;
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_3000; bus.mem_req_ready = 1;
    settle();
    chk1("t5_ifu_ready_after", bus.ifu_req_ready, 1'b1);
    advance();
    bus.ifu_req_valid = 0;
    settle();
    chk64("t5_mem_addr_after", bus.mem_req_addr, 64'h8000_3000);
    advance();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h55;
    settle();
    chk1("t5_ifu_resp_after", bus.ifu_resp_valid, 1'b1);
    chk64("t5_ifu_data_after", bus.ifu_resp_data, 64'h55);
    advance();
    clear_inputs();

    // Randomized traffic against the model
    ifu_pend = 0; lsu_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      settle();
      if (g_if) ifu_pend = 0;
      if (g_ls) lsu_pend = 0;
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
